execute_pipe: RTL and testbench
===============================

// Module: execute_pipe
// PURPOSE
//  Parametrised execute stage between decode and memory. Valid/ready handshake on both sides.
//  Resolves branches/jumps and evaluates ALU ops. Optionally runs RV32M mul/div as an iterative
//  multi-cycle operation. Results are buffered in an OUT_DEPTH-entry output queue for full throughput.
// PARAMETERS
//  XLEN       32  datapath width (>=8)
//  OUT_DEPTH  2   output queue entries (1 or 2); 2 gives full throughput under back-pressure
// PORTS
//  aclk      in   1     clock, rising edge
//  aresetn   in   1     asynchronous active-low reset
//  flush     in   1     sync discard of queued/in-flight work
//  s_tvalid  in   1     input beat valid
//  s_tready  out  1     input beat accepted when s_tvalid&s_tready
//  s_pc      in   XLEN  instruction PC
//  s_op1/s_op2 in XLEN  ALU operands
//  s_rs1/s_rs2 in XLEN  compare operands
//  s_fun     in   5     0 ADD,1 SUB,2 SLL,3 SLT,4 SLTU,5 XOR,6 SRL,7 SRA,8 OR,9 AND,10 PASS op2;
//                       16..23 MUL,MULH,MULHSU,MULHU,DIV,DIVU,REM,REMU
//  s_jmp     in   3     0 NONE,1 JAL/JALR,2 BEQ,3 BNE,4 BLT,5 BGE,6 BLTU,7 BGEU
//  s_op      in   2     memory op, passed through (0 = NULL)
//  s_rd      in   5     dest register, passed through
//  m_tvalid  out  1     output beat valid
//  m_tready  in   1     downstream accepts
//  m_op/m_rd out  2/5   passed-through fields
//  m_result  out  XLEN  result (pc+4 for JAL/JALR)
//  branch    out  1     one-cycle pulse: taken branch/jump
//  target    out  XLEN  redirect address, valid while branch=1
// BEHAVIOUR
//  - Reset (async): queue empty, m_tvalid=0, m_op=0, m_rd=0, m_result=0, branch=0, target=0, FSM IDLE.
//  - s_tready = ~flush & FSM==IDLE & (count<OUT_DEPTH | m_tready). Pop-and-push same cycle on full allowed.
//  - Shift amounts use op2[log2(XLEN)-1:0]; SLT/BLT/BGE signed, SLTU/BLTU/BGEU unsigned; sums wrap mod 2^XLEN.
//  - Single-cycle ops: accepted at edge k -> visible in queue at k+1 (m_tvalid=1 at k+1 if queue was empty).
//  - Branch: evaluated on accept; taken -> branch=1 and target=(op1+op2)&~1 in the cycle after
//    the accept, for exactly one cycle. Not taken/NONE -> branch=0. Jumps write m_result=pc+4.
//  - The branch pulse is independent of m_tready. A stalled result still redirects once.
//  - FSM: IDLE -(accept fun 16..23)-> BUSY (XLEN iterations, one bit/cycle) -> DONE -(queue slot)-> IDLE.
//    Result is enqueued XLEN+1 cycles after accept if there is room. DONE holds until a slot frees.
//    s_tready=0 in BUSY/DONE. M ops never assert branch.
//  - DIV/DIVU by zero: quotient all-ones, remainder=dividend. DIV overflow (-2^(XLEN-1)/-1):
//    quotient=dividend, remainder 0. MULH* return upper XLEN bits of 2*XLEN product.
//  - flush (sync, highest priority): queue emptied, FSM->IDLE (in-flight M op discarded),
//    branch forced 0 next cycle, no beat accepted in flush cycle.
//  - Queue order is strictly FIFO. m_* outputs are stable while m_tvalid&~m_tready.
// CONFIGURATION
//  EXECUTE_MULDIV_EN defined: fun 16..23 run on the iterative FSM as above.
//  Not defined: fun 16..23 complete in one cycle with m_result=0. No FSM logic is built,
//  and s_tready ignores the FSM term.
// TESTING
//  1. ADD op1=5,op2=7, m_tready=1 -> m_result=12 one cycle after accept; back-to-back beats at 1/clk.
//  2. BEQ rs1=rs2=3, op1=0x100,op2=0x21, pc=0x40 -> branch=1 for one cycle, target=0x120.
//     BNE with the same operands -> branch=0.
//  3. JAL pc=0x80 -> m_result=0x84, branch=1. SRA 0x80000000 by 4 -> 0xF8000000.
//  4. m_tready=0, 3 ALU beats -> OUT_DEPTH beats queued, s_tready=0. m_tready=1 -> all drain in order.
//  5. [MULDIV] DIV 7/0 -> 0xFFFFFFFF after 33 cycles. DIV 0x80000000/-1 -> 0x80000000.
//     MULHU 0xFFFFFFFF^2 -> 0xFFFFFFFE.
//  6. flush during BUSY with queue non-empty -> m_tvalid=0 next cycle; next accepted ADD returns correctly.

Source files
------------

// File: rtl/execute_pipe.sv
// execute_pipe: ALU, branch resolution and an OUT_DEPTH-entry in-order result queue.
// Define EXECUTE_MULDIV_EN to run fun 16..23 (RV32M) on an iterative one-bit-per-cycle unit.
module execute_pipe #(
  parameter int XLEN      = 32,
  parameter int OUT_DEPTH = 2
) (
  input  logic            aclk,
  input  logic            aresetn,
  input  logic            flush,
  input  logic            s_tvalid,
  output logic            s_tready,
  input  logic [XLEN-1:0] s_pc,
  input  logic [XLEN-1:0] s_op1,
  input  logic [XLEN-1:0] s_op2,
  input  logic [XLEN-1:0] s_rs1,
  input  logic [XLEN-1:0] s_rs2,
  input  logic [4:0]      s_fun,
  input  logic [2:0]      s_jmp,
  input  logic [1:0]      s_op,
  input  logic [4:0]      s_rd,
  output logic            m_tvalid,
  input  logic            m_tready,
  output logic [1:0]      m_op,
  output logic [4:0]      m_rd,
  output logic [XLEN-1:0] m_result,
  output logic            branch,
  output logic [XLEN-1:0] target
);

  localparam int SHW = $clog2(XLEN);
  localparam int CW  = $clog2(OUT_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(OUT_DEPTH);

  logic [XLEN-1:0] r_q_res [OUT_DEPTH];
  logic [1:0]      r_q_op  [OUT_DEPTH];
  logic [4:0]      r_q_rd  [OUT_DEPTH];
  logic [XLEN-1:0] w_q_res_nxt [OUT_DEPTH];
  logic [1:0]      w_q_op_nxt  [OUT_DEPTH];
  logic [4:0]      w_q_rd_nxt  [OUT_DEPTH];
  logic [CW-1:0]   r_count;
  logic [CW-1:0]   w_cnt_pop;

  logic            w_room;
  logic            w_accept;
  logic            w_is_m;
  logic            w_pop;
  logic            w_push;
  logic [XLEN-1:0] w_push_res;
  logic [1:0]      w_push_op;
  logic [4:0]      w_push_rd;
  logic [XLEN-1:0] w_alu;
  logic            w_taken;
  logic            r_branch;
  logic [XLEN-1:0] r_target;

  assign w_room   = (r_count < DEPTH_C) | m_tready;
  assign w_accept = s_tvalid & s_tready;
  assign w_is_m   = s_fun[4] & ~s_fun[3];
  assign m_tvalid = (r_count != '0);
  assign w_pop    = m_tvalid & m_tready;

  always_comb begin
    w_alu = '0;
    case (s_fun)
      5'd0:    w_alu = s_op1 + s_op2;
      5'd1:    w_alu = s_op1 - s_op2;
      5'd2:    w_alu = s_op1 << s_op2[SHW-1:0];
      5'd3:    w_alu = {{(XLEN-1){1'b0}}, ($signed(s_op1) < $signed(s_op2))};
      5'd4:    w_alu = {{(XLEN-1){1'b0}}, (s_op1 < s_op2)};
      5'd5:    w_alu = s_op1 ^ s_op2;
      5'd6:    w_alu = s_op1 >> s_op2[SHW-1:0];
      5'd7:    w_alu = $unsigned($signed(s_op1) >>> s_op2[SHW-1:0]);
      5'd8:    w_alu = s_op1 | s_op2;
      5'd9:    w_alu = s_op1 & s_op2;
      5'd10:   w_alu = s_op2;
      default: w_alu = '0;
    endcase
    if (s_jmp == 3'd1) w_alu = s_pc + XLEN'(4);
  end

  always_comb begin
    w_taken = 1'b0;
    case (s_jmp)
      3'd1:    w_taken = 1'b1;
      3'd2:    w_taken = (s_rs1 == s_rs2);
      3'd3:    w_taken = (s_rs1 != s_rs2);
      3'd4:    w_taken = ($signed(s_rs1) < $signed(s_rs2));
      3'd5:    w_taken = ($signed(s_rs1) >= $signed(s_rs2));
      3'd6:    w_taken = (s_rs1 < s_rs2);
      3'd7:    w_taken = (s_rs1 >= s_rs2);
      default: w_taken = 1'b0;
    endcase
  end

  // Redirect is registered at accept so it fires once even if the result stalls in the queue.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_branch <= 1'b0;
      r_target <= '0;
    end else begin
      r_branch <= 1'b0;
      if (!flush && w_accept && w_taken && !w_is_m) begin
        r_branch <= 1'b1;
        r_target <= (s_op1 + s_op2) & ~XLEN'(1);
      end
    end
  end

  assign branch = r_branch;
  assign target = r_target;

`ifdef EXECUTE_MULDIV_EN
  localparam int CNTW = (SHW < 1) ? 1 : SHW;

  // IDLE accepting beats | BUSY one bit per cycle | DONE result waiting for a queue slot
  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;
  state_t r_state, w_state_nxt;

  logic [CNTW-1:0] r_cnt;
  logic [2:0]      r_md_fun;
  logic [1:0]      r_md_op;
  logic [4:0]      r_md_rd;
  logic [XLEN-1:0] r_hi, r_lo, r_mcand, r_dividend;
  logic            r_neg_a, r_neg_b, r_dz;
  logic            w_md_start, w_md_push;
  logic            w_sgn1, w_sgn2, w_n1, w_n2;
  logic [XLEN-1:0] w_a1, w_a2;
  logic [XLEN:0]   w_madd, w_rs, w_diff;
  logic [2*XLEN-1:0] w_prod, w_prod_s;
  logic [XLEN-1:0] w_md_res;

  assign w_md_start = w_accept & w_is_m;
  assign w_md_push  = (r_state == ST_DONE) & w_room & ~flush;
  assign s_tready   = ~flush & (r_state == ST_IDLE) & w_room;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_md_start) w_state_nxt = ST_BUSY;
      ST_BUSY: if (r_cnt == '0) w_state_nxt = ST_DONE;
      ST_DONE: if (w_room) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
    if (flush) w_state_nxt = ST_IDLE;
  end

  // Signed forms run on magnitudes; signs are reapplied when the result is read out.
  assign w_sgn1 = (s_fun[2:0] == 3'd1) | (s_fun[2:0] == 3'd2) |
                  (s_fun[2:0] == 3'd4) | (s_fun[2:0] == 3'd6);
  assign w_sgn2 = (s_fun[2:0] == 3'd1) | (s_fun[2:0] == 3'd4) | (s_fun[2:0] == 3'd6);
  assign w_n1   = w_sgn1 & s_op1[XLEN-1];
  assign w_n2   = w_sgn2 & s_op2[XLEN-1];
  assign w_a1   = w_n1 ? (~s_op1 + XLEN'(1)) : s_op1;
  assign w_a2   = w_n2 ? (~s_op2 + XLEN'(1)) : s_op2;

  assign w_madd = {1'b0, r_hi} + {1'b0, (r_lo[0] ? r_mcand : '0)};
  assign w_rs   = {r_hi, r_lo[XLEN-1]};
  assign w_diff = w_rs - {1'b0, r_mcand};

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_cnt      <= '0;
      r_md_fun   <= '0;
      r_md_op    <= '0;
      r_md_rd    <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_mcand    <= '0;
      r_dividend <= '0;
      r_neg_a    <= 1'b0;
      r_neg_b    <= 1'b0;
      r_dz       <= 1'b0;
    end else if (r_state == ST_IDLE) begin
      if (w_md_start && !flush) begin
        r_cnt      <= CNTW'(XLEN - 1);
        r_md_fun   <= s_fun[2:0];
        r_md_op    <= s_op;
        r_md_rd    <= s_rd;
        r_hi       <= '0;
        r_lo       <= s_fun[2] ? w_a1 : w_a2;
        r_mcand    <= s_fun[2] ? w_a2 : w_a1;
        r_dividend <= s_op1;
        r_neg_a    <= w_n1 ^ w_n2;
        r_neg_b    <= w_n1;
        r_dz       <= (s_op2 == '0);
      end
    end else if (r_state == ST_BUSY) begin
      r_cnt <= r_cnt - CNTW'(1);
      if (!r_md_fun[2]) begin
        r_hi <= w_madd[XLEN:1];
        r_lo <= {w_madd[0], r_lo[XLEN-1:1]};
      end else if (!w_diff[XLEN]) begin
        r_hi <= w_diff[XLEN-1:0];
        r_lo <= {r_lo[XLEN-2:0], 1'b1};
      end else begin
        r_hi <= w_rs[XLEN-1:0];
        r_lo <= {r_lo[XLEN-2:0], 1'b0};
      end
    end
  end

  assign w_prod   = {r_hi, r_lo};
  assign w_prod_s = r_neg_a ? (~w_prod + (2*XLEN)'(1)) : w_prod;

  always_comb begin
    w_md_res = '0;
    case (r_md_fun)
      3'd0:          w_md_res = w_prod_s[XLEN-1:0];
      3'd1, 3'd2,
      3'd3:          w_md_res = w_prod_s[2*XLEN-1:XLEN];
      3'd4, 3'd5:    w_md_res = r_dz ? '1 : (r_neg_a ? (~r_lo + XLEN'(1)) : r_lo);
      default:       w_md_res = r_dz ? r_dividend : (r_neg_b ? (~r_hi + XLEN'(1)) : r_hi);
    endcase
  end

  always_comb begin
    w_push     = (w_accept & ~w_is_m) | w_md_push;
    w_push_res = w_md_push ? w_md_res : w_alu;
    w_push_op  = w_md_push ? r_md_op  : s_op;
    w_push_rd  = w_md_push ? r_md_rd  : s_rd;
  end
`else
  assign s_tready = ~flush & w_room;

  always_comb begin
    w_push     = w_accept;
    w_push_res = w_alu;
    w_push_op  = s_op;
    w_push_rd  = s_rd;
  end
`endif

  // Shift-register FIFO: entry 0 is always the head, so m_* come straight from flops.
  always_comb begin
    w_cnt_pop = r_count - {{(CW-1){1'b0}}, w_pop};
    for (int i = 0; i < OUT_DEPTH; i++) begin
      w_q_res_nxt[i] = r_q_res[i];
      w_q_op_nxt[i]  = r_q_op[i];
      w_q_rd_nxt[i]  = r_q_rd[i];
      if (w_pop && (i < OUT_DEPTH - 1)) begin
        w_q_res_nxt[i] = r_q_res[(i < OUT_DEPTH - 1) ? i + 1 : i];
        w_q_op_nxt[i]  = r_q_op[(i < OUT_DEPTH - 1) ? i + 1 : i];
        w_q_rd_nxt[i]  = r_q_rd[(i < OUT_DEPTH - 1) ? i + 1 : i];
      end
      if (w_push && (CW'(i) == w_cnt_pop)) begin
        w_q_res_nxt[i] = w_push_res;
        w_q_op_nxt[i]  = w_push_op;
        w_q_rd_nxt[i]  = w_push_rd;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_count <= '0;
      for (int i = 0; i < OUT_DEPTH; i++) begin
        r_q_res[i] <= '0;
        r_q_op[i]  <= '0;
        r_q_rd[i]  <= '0;
      end
    end else if (flush) begin
      r_count <= '0;
    end else begin
      r_count <= w_cnt_pop + {{(CW-1){1'b0}}, w_push};
      for (int i = 0; i < OUT_DEPTH; i++) begin
        r_q_res[i] <= w_q_res_nxt[i];
        r_q_op[i]  <= w_q_op_nxt[i];
        r_q_rd[i]  <= w_q_rd_nxt[i];
      end
    end
  end

  assign m_result = r_q_res[0];
  assign m_op     = r_q_op[0];
  assign m_rd     = r_q_rd[0];

endmodule

// File: tb/tb_execute_pipe.sv
// Directed bench for execute_pipe: vector table for ALU/branch ops, hand sequences for
// back-pressure, stalled redirect, flush and (when EXECUTE_MULDIV_EN is defined) mul/div.
module tb_execute_pipe;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        flush;
  logic        s_tvalid;
  logic        s_tready;
  logic [31:0] s_pc, s_op1, s_op2, s_rs1, s_rs2;
  logic [4:0]  s_fun;
  logic [2:0]  s_jmp;
  logic [1:0]  s_op;
  logic [4:0]  s_rd;
  logic        m_tvalid;
  logic        m_tready;
  logic [1:0]  m_op;
  logic [4:0]  m_rd;
  logic [31:0] m_result;
  logic        branch;
  logic [31:0] target;

  int n_cmp = 0;
  int n_err = 0;

  execute_pipe #(.XLEN(32), .OUT_DEPTH(2)) dut (
    .aclk(aclk), .aresetn(aresetn), .flush(flush),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_pc(s_pc),
    .s_op1(s_op1), .s_op2(s_op2), .s_rs1(s_rs1), .s_rs2(s_rs2),
    .s_fun(s_fun), .s_jmp(s_jmp), .s_op(s_op), .s_rd(s_rd),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_op(m_op), .m_rd(m_rd),
    .m_result(m_result), .branch(branch), .target(target)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [4:0]  fun;
    logic [2:0]  jmp;
    logic [31:0] pc, op1, op2, rs1, rs2;
    logic [31:0] res;
    logic        br;
    logic [31:0] tgt;
  } vec_t;

  vec_t tbl [20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input logic [4:0] fun, input logic [2:0] jmp, input logic [31:0] pc,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] r1, input logic [31:0] r2, input logic [4:0] rd);
    s_fun = fun; s_jmp = jmp; s_pc = pc; s_op1 = a; s_op2 = b;
    s_rs1 = r1; s_rs2 = r2; s_rd = rd; s_op = rd[1:0];
    s_tvalid = 1'b1;
  endtask

`ifdef EXECUTE_MULDIV_EN
  task automatic md_run(input string name, input logic [4:0] fun, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    int lat;
    @(negedge aclk);
    m_tready = 1'b1;
    apply(fun, 3'd0, 32'h0, a, b, 32'h0, 32'h0, 5'd9);
    @(posedge aclk); #1;
    s_tvalid = 1'b0;
    chk({name, "_tready_busy"}, {31'h0, s_tready}, 32'h0);
    lat = 0;
    while (!m_tvalid && lat < 100) begin
      @(posedge aclk); #1;
      lat++;
      if (branch) chk({name, "_no_branch"}, {31'h0, branch}, 32'h0);
    end
    chk({name, "_latency"}, lat, 33);
    chk({name, "_result"}, m_result, exp);
    @(posedge aclk); #1;
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            fun    jmp   pc        op1           op2           rs1           rs2           res           br    tgt
    tbl[0]  = '{5'd0,  3'd0, 32'h0,  32'd5,        32'd7,        32'h0,        32'h0,        32'd12,       1'b0, 32'h0};
    tbl[1]  = '{5'd1,  3'd0, 32'h0,  32'd5,        32'd7,        32'h0,        32'h0,        32'hFFFFFFFE, 1'b0, 32'h0};
    tbl[2]  = '{5'd2,  3'd0, 32'h0,  32'd1,        32'd33,       32'h0,        32'h0,        32'd2,        1'b0, 32'h0};
    tbl[3]  = '{5'd3,  3'd0, 32'h0,  32'hFFFFFFFF, 32'd1,        32'h0,        32'h0,        32'd1,        1'b0, 32'h0};
    tbl[4]  = '{5'd4,  3'd0, 32'h0,  32'hFFFFFFFF, 32'd1,        32'h0,        32'h0,        32'd0,        1'b0, 32'h0};
    tbl[5]  = '{5'd5,  3'd0, 32'h0,  32'h0000F0F0, 32'h0000FF00, 32'h0,        32'h0,        32'h00000FF0, 1'b0, 32'h0};
    tbl[6]  = '{5'd6,  3'd0, 32'h0,  32'h80000000, 32'd4,        32'h0,        32'h0,        32'h08000000, 1'b0, 32'h0};
    tbl[7]  = '{5'd7,  3'd0, 32'h0,  32'h80000000, 32'd4,        32'h0,        32'h0,        32'hF8000000, 1'b0, 32'h0};
    tbl[8]  = '{5'd8,  3'd0, 32'h0,  32'h0F,       32'hF0,       32'h0,        32'h0,        32'hFF,       1'b0, 32'h0};
    tbl[9]  = '{5'd9,  3'd0, 32'h0,  32'h0F,       32'hFC,       32'h0,        32'h0,        32'h0C,       1'b0, 32'h0};
    tbl[10] = '{5'd10, 3'd0, 32'h0,  32'hDEAD,     32'h1234,     32'h0,        32'h0,        32'h1234,     1'b0, 32'h0};
    tbl[11] = '{5'd0,  3'd0, 32'h0,  32'hFFFFFFFF, 32'd1,        32'h0,        32'h0,        32'h0,        1'b0, 32'h0};
    tbl[12] = '{5'd0,  3'd2, 32'h40, 32'h100,      32'h21,       32'd3,        32'd3,        32'h121,      1'b1, 32'h120};
    tbl[13] = '{5'd0,  3'd3, 32'h40, 32'h100,      32'h21,       32'd3,        32'd3,        32'h121,      1'b0, 32'h0};
    tbl[14] = '{5'd0,  3'd1, 32'h80, 32'h200,      32'h5,        32'h0,        32'h0,        32'h84,       1'b1, 32'h204};
    tbl[15] = '{5'd0,  3'd4, 32'h0,  32'h300,      32'h0,        32'hFFFFFFFF, 32'd1,        32'h300,      1'b1, 32'h300};
    tbl[16] = '{5'd0,  3'd6, 32'h0,  32'h10,       32'h0,        32'hFFFFFFFF, 32'd1,        32'h10,       1'b0, 32'h0};
    tbl[17] = '{5'd0,  3'd5, 32'h0,  32'h10,       32'h10,       32'd1,        32'hFFFFFFFF, 32'h20,       1'b1, 32'h20};
    tbl[18] = '{5'd0,  3'd7, 32'h0,  32'h40,       32'h1,        32'd5,        32'd5,        32'h41,       1'b1, 32'h40};
    tbl[19] = '{5'd0,  3'd4, 32'h0,  32'h8,        32'h8,        32'd1,        32'hFFFFFFFF, 32'h10,       1'b0, 32'h0};

    aresetn = 1'b0; flush = 1'b0; s_tvalid = 1'b0; m_tready = 1'b0;
    s_pc = '0; s_op1 = '0; s_op2 = '0; s_rs1 = '0; s_rs2 = '0;
    s_fun = '0; s_jmp = '0; s_op = '0; s_rd = '0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
    #1;
    chk("rst_m_tvalid", {31'h0, m_tvalid}, 32'h0);
    chk("rst_m_result", m_result, 32'h0);
    chk("rst_m_rd", {27'h0, m_rd}, 32'h0);
    chk("rst_m_op", {30'h0, m_op}, 32'h0);
    chk("rst_branch", {31'h0, branch}, 32'h0);
    chk("rst_target", target, 32'h0);
    chk("rst_s_tready", {31'h0, s_tready}, 32'h1);

    // Vector table, back-to-back at one beat per clock with m_tready held high.
    @(negedge aclk);
    m_tready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      apply(tbl[i].fun, tbl[i].jmp, tbl[i].pc, tbl[i].op1, tbl[i].op2,
            tbl[i].rs1, tbl[i].rs2, 5'(i));
      #1;
      chk($sformatf("vec%0d_s_tready", i), {31'h0, s_tready}, 32'h1);
      @(posedge aclk); #1;
      chk($sformatf("vec%0d_m_tvalid", i), {31'h0, m_tvalid}, 32'h1);
      chk($sformatf("vec%0d_result", i), m_result, tbl[i].res);
      chk($sformatf("vec%0d_rd", i), {27'h0, m_rd}, 32'(i));
      chk($sformatf("vec%0d_op", i), {30'h0, m_op}, 32'(i % 4));
      chk($sformatf("vec%0d_branch", i), {31'h0, branch}, {31'h0, tbl[i].br});
      if (tbl[i].br) chk($sformatf("vec%0d_target", i), target, tbl[i].tgt);
      @(negedge aclk);
    end
    s_tvalid = 1'b0;
    @(posedge aclk); #1;
    chk("drain_m_tvalid", {31'h0, m_tvalid}, 32'h0);
    chk("drain_branch", {31'h0, branch}, 32'h0);

    // Stalled JAL still redirects exactly once.
    @(negedge aclk);
    m_tready = 1'b0;
    apply(5'd0, 3'd1, 32'h80, 32'h1000, 32'h11, 32'h0, 32'h0, 5'd7);
    @(posedge aclk); #1;
    s_tvalid = 1'b0;
    chk("jal_stall_branch", {31'h0, branch}, 32'h1);
    chk("jal_stall_target", target, 32'h1010);
    chk("jal_stall_result", m_result, 32'h84);
    @(posedge aclk); #1;
    chk("jal_stall_pulse_end", {31'h0, branch}, 32'h0);
    chk("jal_stall_m_tvalid", {31'h0, m_tvalid}, 32'h1);
    @(negedge aclk);
    m_tready = 1'b1;
    @(posedge aclk); #1;
    chk("jal_stall_drained", {31'h0, m_tvalid}, 32'h0);

    // Back-pressure: three ALU beats against a two-entry queue, then drain in order.
    @(negedge aclk);
    m_tready = 1'b0;
    apply(5'd0, 3'd0, 32'h0, 32'd1, 32'd1, 32'h0, 32'h0, 5'd1);
    @(posedge aclk); #1;
    chk("bp_first_result", m_result, 32'd2);
    @(negedge aclk);
    apply(5'd0, 3'd0, 32'h0, 32'd1, 32'd2, 32'h0, 32'h0, 5'd2);
    #1;
    chk("bp_second_tready", {31'h0, s_tready}, 32'h1);
    @(posedge aclk); #1;
    @(negedge aclk);
    apply(5'd0, 3'd0, 32'h0, 32'd2, 32'd2, 32'h0, 32'h0, 5'd3);
    #1;
    chk("bp_full_tready", {31'h0, s_tready}, 32'h0);
    @(posedge aclk); #1;
    chk("bp_stable_result", m_result, 32'd2);
    chk("bp_stable_rd", {27'h0, m_rd}, 32'd1);
    @(negedge aclk);
    m_tready = 1'b1;
    #1;
    chk("bp_pop_push_tready", {31'h0, s_tready}, 32'h1);
    @(posedge aclk); #1;
    s_tvalid = 1'b0;
    chk("bp_order_2", m_result, 32'd3);
    @(posedge aclk); #1;
    chk("bp_order_3", m_result, 32'd4);
    chk("bp_order_3_rd", {27'h0, m_rd}, 32'd3);
    @(posedge aclk); #1;
    chk("bp_empty", {31'h0, m_tvalid}, 32'h0);

`ifdef EXECUTE_MULDIV_EN
    md_run("div_by_zero", 5'd20, 32'd7, 32'd0, 32'hFFFFFFFF);
    md_run("div_overflow", 5'd20, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
    md_run("mulhu_max", 5'd19, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
    md_run("mul_small", 5'd16, 32'd6, 32'd7, 32'd42);
    md_run("mulh_neg", 5'd17, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF);
    md_run("rem_neg", 5'd22, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF);
    md_run("divu_plain", 5'd21, 32'd100, 32'd7, 32'd14);

    // Flush while the iterative unit is busy and the queue holds a result.
    @(negedge aclk);
    m_tready = 1'b0;
    apply(5'd0, 3'd0, 32'h0, 32'd1, 32'd1, 32'h0, 32'h0, 5'd1);
    @(posedge aclk); #1;
    @(negedge aclk);
    apply(5'd20, 3'd0, 32'h0, 32'd50, 32'd5, 32'h0, 32'h0, 5'd2);
    @(posedge aclk); #1;
    s_tvalid = 1'b0;
    repeat (4) @(posedge aclk);
    @(negedge aclk);
    flush = 1'b1;
    @(posedge aclk); #1;
    flush = 1'b0;
    chk("mdflush_m_tvalid", {31'h0, m_tvalid}, 32'h0);
    chk("mdflush_idle_tready", {31'h0, s_tready}, 32'h1);
`else
    // Without the iterative unit, M ops finish in one cycle with a zero result.
    @(negedge aclk);
    m_tready = 1'b1;
    apply(5'd16, 3'd0, 32'h0, 32'd3, 32'd4, 32'h0, 32'h0, 5'd4);
    @(posedge aclk); #1;
    s_tvalid = 1'b0;
    chk("mul_off_m_tvalid", {31'h0, m_tvalid}, 32'h1);
    chk("mul_off_result", m_result, 32'h0);
    @(posedge aclk); #1;

    // Flush with a full queue and a taken branch offered in the flush cycle.
    @(negedge aclk);
    m_tready = 1'b0;
    apply(5'd0, 3'd0, 32'h0, 32'd1, 32'd2, 32'h0, 32'h0, 5'd1);
    @(posedge aclk); #1;
    @(negedge aclk);
    apply(5'd0, 3'd0, 32'h0, 32'd3, 32'd4, 32'h0, 32'h0, 5'd2);
    @(posedge aclk); #1;
    @(negedge aclk);
    flush = 1'b1;
    m_tready = 1'b1;
    apply(5'd0, 3'd2, 32'h0, 32'h100, 32'h0, 32'd9, 32'd9, 5'd3);
    #1;
    chk("flush_tready", {31'h0, s_tready}, 32'h0);
    @(posedge aclk); #1;
    chk("flush_m_tvalid", {31'h0, m_tvalid}, 32'h0);
    chk("flush_branch", {31'h0, branch}, 32'h0);
    s_tvalid = 1'b0;
`endif

    @(negedge aclk);
    flush = 1'b0;
    m_tready = 1'b1;
    apply(5'd0, 3'd0, 32'h0, 32'd20, 32'd22, 32'h0, 32'h0, 5'd5);
    #1;
    chk("post_flush_tready", {31'h0, s_tready}, 32'h1);
    @(posedge aclk); #1;
    s_tvalid = 1'b0;
    chk("post_flush_m_tvalid", {31'h0, m_tvalid}, 32'h1);
    chk("post_flush_result", m_result, 32'd42);
    chk("post_flush_rd", {27'h0, m_rd}, 32'd5);
    @(posedge aclk); #1;
    chk("post_flush_empty", {31'h0, m_tvalid}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
